// File: rtl/dequantizer_pkg.sv
// ----------------------------------------------------------------------------
// dequantizer_pkg
//   Shared definitions for the dequantiser block: default widths, the block
//   FSM state type and the zigzag-scan -> raster lookup table.
//   No ports (package).
// ----------------------------------------------------------------------------
package dequantizer_pkg;

    localparam int DEF_COEF_BIT   = 12;
    localparam int DEF_QT_BIT     = 8;
    localparam int DEF_Q_BIT      = 32;
    localparam int DEF_Q_FRAC_BIT = 16;
    localparam int DEF_BLOCK_BIT  = 3;

    // BOSTA: idle, AKIS: streaming a block, SON: waiting to emit the terminator
    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        AKIS  = 2'd1,
        SON   = 2'd2
    } dq_state_t;

    // Entry n is the raster position of the n-th coefficient in JPEG zigzag order
    localparam logic [5:0] ZIGZAG_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zigzag_to_raster(input logic [5:0] zz);
        return ZIGZAG_LUT[zz];
    endfunction

endpackage

// File: rtl/dq_carpici.sv
// ----------------------------------------------------------------------------
// dq_carpici
//   Registered multiply / fixed-point shift / saturate stage.
//   result = sat( coef * qt <<< Q_FRAC_BIT ) into signed Q_BIT.
// Ports:
//   clk_i     clock
//   rstn_i    synchronous reset, active low (clears result)
//   en_i      load enable (pipeline advance)
//   coef_i    signed coefficient
//   qt_i      unsigned quantisation factor
//   result_o  registered saturated product, signed Q_BIT
// ----------------------------------------------------------------------------
module dq_carpici #(
    parameter int COEF_BIT   = 12,
    parameter int QT_BIT     = 8,
    parameter int Q_BIT      = 32,
    parameter int Q_FRAC_BIT = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       en_i,
    input  logic signed [COEF_BIT-1:0] coef_i,
    input  logic        [QT_BIT-1:0]   qt_i,
    output logic signed [Q_BIT-1:0]    result_o
);

    localparam int PROD_BIT  = COEF_BIT + QT_BIT + 1;
    localparam int SHIFT_BIT = PROD_BIT + Q_FRAC_BIT;
    // Compare in a width that holds both the shifted product and the output range
    localparam int EXT_BIT   = (SHIFT_BIT > Q_BIT) ? SHIFT_BIT : Q_BIT;

    logic signed [PROD_BIT-1:0] prod;
    logic signed [EXT_BIT-1:0]  shifted;
    logic signed [EXT_BIT-1:0]  max_v;
    logic signed [EXT_BIT-1:0]  min_v;
    logic signed [Q_BIT-1:0]    sat;

    always_comb begin
        max_v   = {{(EXT_BIT-Q_BIT+1){1'b0}}, {(Q_BIT-1){1'b1}}};
        min_v   = {{(EXT_BIT-Q_BIT+1){1'b1}}, {(Q_BIT-1){1'b0}}};
        // qt is unsigned: zero-extend before the signed multiply
        prod    = PROD_BIT'(coef_i) * PROD_BIT'($signed({1'b0, qt_i}));
        shifted = EXT_BIT'(prod) <<< Q_FRAC_BIT;
        if (shifted > max_v) begin
            sat = {1'b0, {(Q_BIT-1){1'b1}}};
        end else if (shifted < min_v) begin
            sat = {1'b1, {(Q_BIT-1){1'b0}}};
        end else begin
            sat = shifted[Q_BIT-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            result_o <= '0;
        end else if (en_i) begin
            result_o <= sat;
        end
    end

endmodule

// File: rtl/dequantizer.sv
// ----------------------------------------------------------------------------
// dequantizer
//   Multiplies sparse quantised coefficients by their quantisation-table entry,
//   converts to signed Q_BIT fixed point and maps the index to (row,col).
//   One output beat per coefficient, then one terminator beat per block.
//   Build option: DEQUANTIZER_ZIGZAG_EN -- hd_index_i is a zigzag scan index
//   and is mapped to raster order in S1; otherwise it is already raster.
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   qt_veri_i/adres_i    quant-table write data / raster address
//   qt_gecerli_i/hazir_o table write request / accept (idle only)
//   hd_veri_i/index_i    signed coefficient / position
//   hd_gecerli_i         beat valid, hd_blok_son_i marks end of block
//   hd_hazir_o           beat accepted when valid & ready
//   dq_veri_o            dequantised coefficient (signed fixed point)
//   dq_row_o/dq_col_o    raster index / 8, raster index % 8
//   dq_gecerli_o         output valid, dq_blok_son_o terminator beat
//   dq_hazir_i           downstream ready
// ----------------------------------------------------------------------------
module dequantizer
    import dequantizer_pkg::*;
#(
    parameter int COEF_BIT   = DEF_COEF_BIT,
    parameter int QT_BIT     = DEF_QT_BIT,
    parameter int Q_BIT      = DEF_Q_BIT,
    parameter int Q_FRAC_BIT = DEF_Q_FRAC_BIT,
    parameter int BLOCK_BIT  = DEF_BLOCK_BIT
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [QT_BIT-1:0]    qt_veri_i,
    input  logic [5:0]           qt_adres_i,
    input  logic                 qt_gecerli_i,
    output logic                 qt_hazir_o,
    input  logic [COEF_BIT-1:0]  hd_veri_i,
    input  logic [5:0]           hd_index_i,
    input  logic                 hd_gecerli_i,
    input  logic                 hd_blok_son_i,
    output logic                 hd_hazir_o,
    output logic [Q_BIT-1:0]     dq_veri_o,
    output logic [BLOCK_BIT-1:0] dq_row_o,
    output logic [BLOCK_BIT-1:0] dq_col_o,
    output logic                 dq_gecerli_o,
    output logic                 dq_blok_son_o,
    input  logic                 dq_hazir_i
);

    dq_state_t state;
    dq_state_t state_next;

    logic [QT_BIT-1:0] qt_table [64];

    logic       advance;
    logic       hd_accept;
    logic       qt_write;
    logic       term_accept;
    logic [5:0] raster;

    logic                       s1_valid;
    logic                       s1_eob;
    logic signed [COEF_BIT-1:0] s1_coef;
    logic        [QT_BIT-1:0]   s1_qt;
    logic        [5:0]          s1_raster;

    logic                       s2_valid;
    logic                       s2_eob;
    logic        [BLOCK_BIT-1:0] s2_row;
    logic        [BLOCK_BIT-1:0] s2_col;
    logic signed [Q_BIT-1:0]    s2_result;

`ifdef DEQUANTIZER_ZIGZAG_EN
    assign raster = zigzag_to_raster(hd_index_i);
`else
    assign raster = hd_index_i;
`endif

    // Stall-all pipeline: both stages move together whenever the output slot frees up
    assign advance     = !s2_valid || dq_hazir_i;
    assign qt_hazir_o  = (state == BOSTA);
    assign hd_hazir_o  = (state != SON) && advance;
    assign hd_accept   = hd_gecerli_i && hd_hazir_o;
    assign qt_write    = qt_gecerli_i && qt_hazir_o;
    // The EOB beat travels the pipeline as a flagged beat, so it naturally
    // leaves after every coefficient of its block
    assign term_accept = s2_valid && s2_eob && dq_hazir_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= BOSTA;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOSTA: if (hd_accept) state_next = hd_blok_son_i ? SON : AKIS;
            AKIS:  if (hd_accept && hd_blok_son_i) state_next = SON;
            SON:   if (term_accept) state_next = BOSTA;
            default: state_next = BOSTA;
        endcase
    end

    // A write coinciding with the first beat of a block still commits, but the
    // S1 read below sees the old entry
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < 64; i++) begin
                qt_table[i] <= QT_BIT'(1);
            end
        end else if (qt_write) begin
            qt_table[qt_adres_i] <= qt_veri_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s1_valid  <= 1'b0;
            s1_eob    <= 1'b0;
            s1_coef   <= '0;
            s1_qt     <= '0;
            s1_raster <= '0;
        end else if (advance) begin
            s1_valid  <= hd_accept;
            s1_eob    <= hd_accept && hd_blok_son_i;
            s1_coef   <= hd_veri_i;
            s1_qt     <= qt_table[raster];
            s1_raster <= raster;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s2_valid <= 1'b0;
            s2_eob   <= 1'b0;
            s2_row   <= '0;
            s2_col   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_eob   <= s1_eob;
            s2_row   <= BLOCK_BIT'(s1_raster[5:3]);
            s2_col   <= BLOCK_BIT'(s1_raster[2:0]);
        end
    end

    dq_carpici #(
        .COEF_BIT   (COEF_BIT),
        .QT_BIT     (QT_BIT),
        .Q_BIT      (Q_BIT),
        .Q_FRAC_BIT (Q_FRAC_BIT)
    ) u_carpici (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (advance),
        .coef_i   (s1_coef),
        .qt_i     (s1_qt),
        .result_o (s2_result)
    );

    assign dq_veri_o     = s2_result;
    assign dq_row_o      = s2_row;
    assign dq_col_o      = s2_col;
    assign dq_gecerli_o  = s2_valid;
    assign dq_blok_son_o = s2_eob;

endmodule

// File: tb/tb_dequantizer.sv
// ----------------------------------------------------------------------------
// tb_dequantizer
//   Self-checking bench for dequantizer (Q_BIT=32, Q_FRAC_BIT=16).
//   Honours DEQUANTIZER_ZIGZAG_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_dequantizer;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  qt_veri_i;
    logic [5:0]  qt_adres_i;
    logic        qt_gecerli_i;
    logic        qt_hazir_o;
    logic [11:0] hd_veri_i;
    logic [5:0]  hd_index_i;
    logic        hd_gecerli_i;
    logic        hd_blok_son_i;
    logic        hd_hazir_o;
    logic [31:0] dq_veri_o;
    logic [2:0]  dq_row_o;
    logic [2:0]  dq_col_o;
    logic        dq_gecerli_o;
    logic        dq_blok_son_o;
    logic        dq_hazir_i;

    always #5 clk = ~clk;

    dequantizer #(
        .COEF_BIT   (12),
        .QT_BIT     (8),
        .Q_BIT      (32),
        .Q_FRAC_BIT (16),
        .BLOCK_BIT  (3)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .qt_veri_i     (qt_veri_i),
        .qt_adres_i    (qt_adres_i),
        .qt_gecerli_i  (qt_gecerli_i),
        .qt_hazir_o    (qt_hazir_o),
        .hd_veri_i     (hd_veri_i),
        .hd_index_i    (hd_index_i),
        .hd_gecerli_i  (hd_gecerli_i),
        .hd_blok_son_i (hd_blok_son_i),
        .hd_hazir_o    (hd_hazir_o),
        .dq_veri_o     (dq_veri_o),
        .dq_row_o      (dq_row_o),
        .dq_col_o      (dq_col_o),
        .dq_gecerli_o  (dq_gecerli_o),
        .dq_blok_son_o (dq_blok_son_o),
        .dq_hazir_i    (dq_hazir_i)
    );

    typedef struct {
        logic        eob;
        logic [31:0] val;
        int          row;
        int          col;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    tbl [64];
    bit    busy, son, lat_check, toggle_rdy, prev_stall;
    bit    hd_acc_flag;
    int    cycle = 0;
    int    term_count = 0, coef_count = 0, qt_acc_count = 0;
    logic [31:0] last_val;
    int    last_row, last_col;
    logic [31:0] pv;
    logic [2:0]  pr, pc;
    logic        pb;
`ifdef DEQUANTIZER_ZIGZAG_EN
    int    zz [64];
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: product scaled by 2^16, clamped to the signed 32-bit range
    function automatic logic [31:0] model_dq(input int coef, input int qt);
        longint q;
        q = longint'(coef) * longint'(qt) * 64'sd65536;
        if (q > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

`ifdef DEQUANTIZER_ZIGZAG_EN
    // Walk the anti-diagonals, alternating direction, to list raster positions
    task automatic build_zz();
        int k;
        int lo;
        int hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask
`endif

    function automatic int to_raster(input int idx);
`ifdef DEQUANTIZER_ZIGZAG_EN
        return zz[idx];
`else
        return idx;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy = 0;
        son = 0;
        prev_stall = 0;
        for (int i = 0; i < 64; i++) tbl[i] = 1;
    endtask

    // One clock: observe at the falling edge, drive just after the rising edge
    task automatic tick();
        beat_t e;
        int    r;
        @(negedge clk);
        cycle++;
        hd_acc_flag = 0;
        if (prev_stall) begin
            check("stall_valid", 64'(dq_gecerli_o), 64'd1);
            check("stall_data", 64'({dq_veri_o, dq_row_o, dq_col_o, dq_blok_son_o}),
                  64'({pv, pr, pc, pb}));
        end
        prev_stall = dq_gecerli_o && !dq_hazir_i;
        pv = dq_veri_o; pr = dq_row_o; pc = dq_col_o; pb = dq_blok_son_o;
        check("qt_hazir", 64'(qt_hazir_o), 64'(!busy));
        if (son) check("hd_hazir_son", 64'(hd_hazir_o), 64'd0);
        if (dq_gecerli_o && dq_hazir_i) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("blok_son", 64'(dq_blok_son_o), 64'(e.eob));
                if (e.eob) begin
                    term_count++;
                    busy = 0;
                    son = 0;
                end else begin
                    check("veri", 64'(dq_veri_o), 64'(e.val));
                    check("row", 64'(dq_row_o), 64'(e.row));
                    check("col", 64'(dq_col_o), 64'(e.col));
                    if (lat_check) check("latency", 64'(cycle - e.cyc), 64'd2);
                    coef_count++;
                    last_val = dq_veri_o;
                    last_row = int'(dq_row_o);
                    last_col = int'(dq_col_o);
                end
            end
        end
        if (hd_gecerli_i && hd_hazir_o) begin
            hd_acc_flag = 1;
            e.eob = hd_blok_son_i;
            e.cyc = cycle;
            if (hd_blok_son_i) begin
                e.val = '0; e.row = 0; e.col = 0;
                son = 1;
            end else begin
                r = to_raster(int'(hd_index_i));
                e.val = model_dq(int'($signed(hd_veri_i)), tbl[r]);
                e.row = r / 8;
                e.col = r % 8;
            end
            exp_q.push_back(e);
            busy = 1;
        end
        if (qt_gecerli_i && qt_hazir_o) begin
            tbl[qt_adres_i] = int'(qt_veri_i);
            qt_acc_count++;
        end
        @(posedge clk);
        #1;
        if (toggle_rdy) dq_hazir_i = !dq_hazir_i;
    endtask

    task automatic send_beat(input int coef, input int idx, input bit eob);
        hd_veri_i     = 12'(coef);
        hd_index_i    = 6'(idx);
        hd_blok_son_i = eob;
        hd_gecerli_i  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (hd_acc_flag) break;
        end
        check("hd_accept_timeout", 64'(hd_acc_flag), 64'd1);
        hd_gecerli_i  = 1'b0;
        hd_blok_son_i = 1'b0;
    endtask

    task automatic qt_write(input int addr, input int val);
        int c0;
        c0 = qt_acc_count;
        qt_adres_i   = 6'(addr);
        qt_veri_i    = 8'(val);
        qt_gecerli_i = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (qt_acc_count != c0) break;
        end
        check("qt_accept_timeout", 64'(qt_acc_count - c0), 64'd1);
        qt_gecerli_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || exp_q.size() > 0) && t < 600) begin
            tick();
            t++;
        end
        check("drain_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, c0, cf, c, q0;
`ifdef DEQUANTIZER_ZIGZAG_EN
        build_zz();
`endif
        rstn_i = 1'b0; dq_hazir_i = 1'b1;
        qt_veri_i = '0; qt_adres_i = '0; qt_gecerli_i = 1'b0;
        hd_veri_i = '0; hd_index_i = '0; hd_gecerli_i = 1'b0; hd_blok_son_i = 1'b0;
        toggle_rdy = 0; lat_check = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gecerli", 64'(dq_gecerli_o), 64'd0);
        check("rst_blok_son", 64'(dq_blok_son_o), 64'd0);
        check("rst_veri", 64'(dq_veri_o), 64'd0);
        check("rst_rowcol", 64'({dq_row_o, dq_col_o}), 64'd0);
        check("rst_qt_hazir", 64'(qt_hazir_o), 64'd1);
        check("rst_hd_hazir", 64'(hd_hazir_o), 64'd1);
        rstn_i = 1'b1;

        // 1: basic block, 2-cycle latency
        lat_check = 1;
        qt_write(1, 5);
        t0 = term_count;
        send_beat(3, 1, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        check("t1_veri", 64'(last_val), 64'h000F_0000);
        check("t1_rowcol", 64'({last_row[2:0], last_col[2:0]}), 64'({3'd0, 3'd1}));
        check("t1_term", 64'(term_count - t0), 64'd1);

        // 2: index mapping
        send_beat(1, 2, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
`ifdef DEQUANTIZER_ZIGZAG_EN
        check("t2_idx2", 64'({last_row[2:0], last_col[2:0]}), 64'({3'd1, 3'd0}));
`else
        check("t2_idx2", 64'({last_row[2:0], last_col[2:0]}), 64'({3'd0, 3'd2}));
`endif
        send_beat(1, 63, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        check("t2_idx63", 64'({last_row[2:0], last_col[2:0]}), 64'({3'd7, 3'd7}));

        // 3: saturation
        qt_write(to_raster(5), 255);
        send_beat(-2048, 5, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        check("t3_neg_sat", 64'(last_val), 64'h8000_0000);
        send_beat(2047, 5, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        check("t3_pos_sat", 64'(last_val), 64'h7FFF_FFFF);

        // 4: 64 random beats with downstream ready toggling
        lat_check = 0;
        for (int i = 0; i < 64; i++) qt_write(i, int'($urandom_range(0, 255)));
        t0 = term_count; cf = coef_count;
        toggle_rdy = 1;
        for (int i = 0; i < 64; i++) begin
            c = int'($urandom_range(0, 4095));
            if (c >= 2048) c = c - 4096;
            send_beat(c, int'($urandom_range(0, 63)), 1'b0);
        end
        send_beat(0, 0, 1'b1);
        drain();
        toggle_rdy = 0;
        dq_hazir_i = 1'b1;
        check("t4_count", 64'(coef_count - cf), 64'd64);
        check("t4_term", 64'(term_count - t0), 64'd1);

        // 5: table write stalls during a block, commits once idle
        send_beat(7, 9, 1'b0);
        q0 = qt_acc_count;
        qt_adres_i = 6'(to_raster(9)); qt_veri_i = 8'd3; qt_gecerli_i = 1'b1;
        tick();
        check("t5_qt_blocked", 64'(qt_acc_count - q0), 64'd0);
        send_beat(0, 0, 1'b1);
        drain();
        for (int t = 0; t < 20 && qt_acc_count == q0; t++) tick();
        qt_gecerli_i = 1'b0;
        check("t5_qt_commit", 64'(qt_acc_count - q0), 64'd1);
        send_beat(7, 9, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        check("t5_new_entry", 64'(last_val), 64'h0015_0000);
        t0 = term_count; cf = coef_count;
        send_beat(0, 0, 1'b1);
        drain();
        repeat (3) tick();
        check("t5_eob_only_term", 64'(term_count - t0), 64'd1);
        check("t5_eob_only_coef", 64'(coef_count - cf), 64'd0);

        // 6: reset with beats in flight
        dq_hazir_i = 1'b0;
        send_beat(100, 12, 1'b0);
        send_beat(-5, 20, 1'b0);
        tick();
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        check("t6_gecerli", 64'(dq_gecerli_o), 64'd0);
        check("t6_blok_son", 64'(dq_blok_son_o), 64'd0);
        check("t6_veri", 64'(dq_veri_o), 64'd0);
        check("t6_qt_hazir", 64'(qt_hazir_o), 64'd1);
        check("t6_hd_hazir", 64'(hd_hazir_o), 64'd1);
        rstn_i = 1'b1;
        dq_hazir_i = 1'b1;
        model_reset();
        t0 = term_count; c0 = coef_count;
        send_beat(100, 12, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        repeat (3) tick();
        check("t6_after_veri", 64'(last_val), 64'h0064_0000);
        check("t6_after_coef", 64'(coef_count - c0), 64'd1);
        check("t6_after_term", 64'(term_count - t0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
